sysbus_arbiter: RTL

- Shares the 64-bit external system bus between two masters: port 0 (CPU core fetch/load/store) and port 1 (DMA/test loader).
- Arbitrates between them, then runs a complete multiplexed bus cycle: address phase, data phase, wait states, completion.
- Drives the nALE, nME, nOE and RnW strobes and the bus tristate enable.
- Sits between the core-level masters and the pad-level Sysbus.

---
 rtl/sysbus_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sysbus_arbiter.sv
// Two-master round-robin arbiter driving a multiplexed 64-bit Sysbus cycle (ADDR, DATA, DONE).
// Optional data-phase abort on a stuck Ready is built when BUS_TIMEOUT_EN is defined.
module sysbus_arbiter #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic        i_we0,
    input  logic        i_we1,
    input  logic [63:0] i_addr0,
    input  logic [63:0] i_addr1,
    input  logic [63:0] i_wdata0,
    input  logic [63:0] i_wdata1,
    output logic        o_gnt0,
    output logic        o_gnt1,
    output logic        o_done0,
    output logic        o_done1,
    output logic [63:0] o_rdata,
    output logic        o_err,
    output logic [63:0] o_bus_out,
    output logic        o_bus_drive,
    input  logic [63:0] i_bus_in,
    input  logic        i_ready,
    output logic        o_nale,
    output logic        o_nme,
    output logic        o_noe,
    output logic        o_rnw
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_owner;
    logic        r_prio;
    logic        r_we;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [3:0]  r_wcnt;
    logic [63:0] r_rdata;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        w_winner;
    logic        w_any_req;
    logic        w_complete;
    logic        w_timeout;

    assign w_any_req  = i_req0 || i_req1;
    // With both requesting the pointer decides; otherwise the lone requester wins.
    assign w_winner   = (i_req0 && i_req1) ? r_prio : !i_req0;
    assign w_complete = (r_state == S_DATA) && (r_wcnt == 4'd0) && i_ready;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] r_tcnt;
    logic          r_err;

    assign w_timeout = (r_state == S_DATA) && (r_wcnt == 4'd0) && !i_ready
                       && (r_tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (r_state == S_ADDR) begin
                r_tcnt <= '0;
            end else if (r_state == S_DATA && r_wcnt == 4'd0 && !i_ready) begin
                r_tcnt <= r_tcnt + TW'(1);
            end
        end
    end

    assign o_err = r_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = |TIMEOUT;
    assign w_timeout        = 1'b0;
    assign o_err            = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next = S_ADDR;
            S_ADDR:  w_next = S_DATA;
            S_DATA:  if (w_complete || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_nale      = 1'b1;
        o_nme       = 1'b1;
        o_noe       = 1'b1;
        o_rnw       = 1'b1;
        o_bus_drive = 1'b0;
        o_bus_out   = '0;
        case (r_state)
            S_ADDR: begin
                o_bus_out   = r_addr;
                o_bus_drive = 1'b1;
                o_nale      = 1'b0;
                o_rnw       = !r_we;
            end
            S_DATA: begin
                o_nme = 1'b0;
                o_rnw = !r_we;
                if (r_we) begin
                    o_bus_out   = r_wdata;
                    o_bus_drive = 1'b1;
                end else begin
                    o_noe = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_prio  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wcnt  <= '0;
            r_rdata <= '0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_winner;
                        r_prio  <= !w_winner;
                        r_we    <= w_winner ? i_we1    : i_we0;
                        r_addr  <= w_winner ? i_addr1  : i_addr0;
                        r_wdata <= w_winner ? i_wdata1 : i_wdata0;
                        r_gnt0  <= !w_winner;
                        r_gnt1  <= w_winner;
                    end
                end
                S_ADDR: r_wcnt <= 4'(WAIT_STATES);
                S_DATA: begin
                    if (r_wcnt != 4'd0) r_wcnt <= r_wcnt - 4'd1;
                    if (w_complete && !r_we) r_rdata <= i_bus_in;
                end
                default: ;
            endcase
        end
    end

    assign o_gnt0  = r_gnt0;
    assign o_gnt1  = r_gnt1;
    assign o_done0 = (r_state == S_DONE) && !r_owner;
    assign o_done1 = (r_state == S_DONE) && r_owner;
    assign o_rdata = r_rdata;

endmodule
